// File: rtl/systolic_x_skew_feeder.sv
// Left-edge X feeder for the systolic array: takes one column per beat and delays
// row i by i cycles so the PE rows see a diagonal wavefront; tracks tile length.

module systolic_x_skew_lane #(
    parameter int DW    = 16,
    parameter int DEPTH = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    output logic [DW-1:0] data_o
);
    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;

    // Free-running shift: the array never backpressures.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= data_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = dat_q[DEPTH-1];
endmodule

module systolic_x_skew_feeder #(
    parameter int ROWS  = 8,
    parameter int DW    = 16,
    parameter int LEN_W = 8
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    input  logic                 I_START,
    input  logic [LEN_W-1:0]     I_LEN,
    input  logic                 I_VLD,
    input  logic [ROWS*DW-1:0]   I_DATA,
    output logic                 O_RDY,
    output logic [ROWS-1:0]      O_X_VLD,
    output logic [ROWS*DW-1:0]   O_X,
    output logic                 O_BUSY,
    output logic                 O_DONE
);
    // One counter serves both beat counting and the drain countdown.
    localparam int CNT_W = (LEN_W > $clog2(ROWS + 1)) ? LEN_W : $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               done_q, done_d;
    logic               accept;
    logic [ROWS-1:0][DW-1:0] lane_in, lane_out;

    assign O_RDY  = (state_q == S_FEED);
    assign O_BUSY = (state_q != S_IDLE);
    assign O_DONE = done_q;
    assign accept = I_VLD & O_RDY;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_START) begin
                    if (I_LEN != '0) begin
                        len_d   = I_LEN;
                        cnt_d   = '0;
                        state_d = S_FEED;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_FEED: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(len_q - LEN_W'(1))) begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_INIT;
                        // Single-row array: the last beat surfaces in the first drain cycle.
                        done_d  = (ROWS == 1);
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    done_d = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Non-accepted cycles inject zero data so invalid slots never carry stale values.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign lane_in[r] = accept ? I_DATA[r*DW +: DW] : '0;

        systolic_x_skew_lane #(
            .DW    (DW),
            .DEPTH (r + 1)
        ) u_lane (
            .clk_i  (I_CLK),
            .rst_i  (I_RST),
            .vld_i  (accept),
            .data_i (lane_in[r]),
            .vld_o  (O_X_VLD[r]),
            .data_o (lane_out[r])
        );

        assign O_X[r*DW +: DW] = lane_out[r];
    end
endmodule

// File: tb/tb_systolic_x_skew_feeder.sv
// Bench for systolic_x_skew_feeder: ROWS=4 instance checked per cycle against a
// cycle-history model, plus a ROWS=1 instance for back-to-back tiles.

module tb_systolic_x_skew_feeder;
    localparam int ROWS  = 4;
    localparam int DW    = 16;
    localparam int LEN_W = 8;
    localparam int HMAX  = 4096;
    localparam int BW    = 3 + ROWS + ROWS*DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, start, vld;
    logic [LEN_W-1:0]    len;
    logic [ROWS*DW-1:0]  data;
    logic                rdy, busy, done;
    logic [ROWS-1:0]     xv;
    logic [ROWS*DW-1:0]  x;

    logic                rst1, start1, vld1;
    logic [LEN_W-1:0]    len1;
    logic [DW-1:0]       data1;
    logic                rdy1, busy1, done1;
    logic [0:0]          xv1;
    logic [DW-1:0]       x1;

    systolic_x_skew_feeder #(.ROWS(ROWS), .DW(DW), .LEN_W(LEN_W)) dut (
        .I_CLK(clk), .I_RST(rst), .I_START(start), .I_LEN(len), .I_VLD(vld),
        .I_DATA(data), .O_RDY(rdy), .O_X_VLD(xv), .O_X(x), .O_BUSY(busy), .O_DONE(done)
    );

    systolic_x_skew_feeder #(.ROWS(1), .DW(DW), .LEN_W(LEN_W)) dut1 (
        .I_CLK(clk), .I_RST(rst1), .I_START(start1), .I_LEN(len1), .I_VLD(vld1),
        .I_DATA(data1), .O_RDY(rdy1), .O_X_VLD(xv1), .O_X(x1), .O_BUSY(busy1), .O_DONE(done1)
    );

    wire [BW-1:0] got_bus = {rdy, busy, done, xv, x};

    int n_chk = 0, n_fail = 0, cyc = 0;

    // Model: which cycles accepted a beat, and the busy/done windows of the tile.
    bit                 acc_v [HMAX];
    logic [ROWS*DW-1:0] acc_d [HMAX];
    bit   m_feed = 0;
    int   m_cnt = 0, m_len = 0, busy_from = -10, done_cyc = -10, zdone_cyc = -10;
    logic [BW-1:0] exp_bus;

    // Apply the inputs of the current cycle, advance one clock, build expectations.
    task automatic step();
        bit idle, acc;
        int s;
        logic [ROWS-1:0]    ev;
        logic [ROWS*DW-1:0] ex;
        idle = !(cyc >= busy_from && cyc <= done_cyc);
        acc  = !rst && m_feed && vld;
        acc_v[cyc] = acc;
        acc_d[cyc] = data;
        if (rst) begin
            m_feed = 0; busy_from = -10; done_cyc = -10; zdone_cyc = -10;
            for (int k = 0; k <= cyc; k++) acc_v[k] = 0;
        end else begin
            if (acc) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_feed   = 0;
                    done_cyc = cyc + ROWS;
                end
            end
            if (idle && start) begin
                if (len != 0) begin
                    m_feed = 1; m_cnt = 0; m_len = int'(len);
                    busy_from = cyc + 1; done_cyc = 1 << 30;
                end else begin
                    zdone_cyc = cyc + 1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        ev = '0;
        ex = '0;
        for (int i = 0; i < ROWS; i++) begin
            s = cyc - 1 - i;
            if (s >= 0 && acc_v[s]) begin
                ev[i] = 1'b1;
                ex[i*DW +: DW] = acc_d[s][i*DW +: DW];
            end
        end
        exp_bus = {m_feed, (cyc >= busy_from && cyc <= done_cyc),
                   (cyc == done_cyc) || (cyc == zdone_cyc), ev, ex};
    endtask

    function automatic logic [ROWS*DW-1:0] beat(int letter);
        logic [ROWS*DW-1:0] b;
        for (int i = 0; i < ROWS; i++) b[i*DW +: DW] = 16'(16'h0A00 + (letter << 8) + i);
        return b;
    endfunction

    task automatic test_reset();
        rst = 1; start = 0; len = '0; vld = 1;
        rst1 = 1; start1 = 0; len1 = '0; vld1 = 1; data1 = 16'hBEEF;
        for (int k = 0; k < 2; k++) begin
            data = {$urandom(), $urandom()};
            step();
            n_chk++;
            if (got_bus !== exp_bus || got_bus !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, got_bus, exp_bus);
            end
        end
        n_chk++;
        if ({rdy1, busy1, done1, xv1, x1} !== '0) begin
            n_fail++;
            $display("FAIL reset_rows1 got=%h exp=0", {rdy1, busy1, done1, xv1, x1});
        end
        rst = 0; rst1 = 0; vld1 = 0;
        step();
        n_chk++;
        if (rdy !== 1'b0 || got_bus !== exp_bus) begin
            n_fail++;
            $display("FAIL reset_idle_rdy got=%h exp=%h", got_bus, exp_bus);
        end
        vld = 0; start = 1; len = 8'd1;
        step();
        start = 0;
        n_chk++;
        if (rdy !== 1'b1 || got_bus !== exp_bus) begin
            n_fail++;
            $display("FAIL reset_rdy_after_start got=%h exp=%h", got_bus, exp_bus);
        end
        vld = 1; data = {$urandom(), $urandom()};
        for (int k = 0; k < 7; k++) begin
            step();
            vld = 0;
            n_chk++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL reset_first_tile cyc=%0d got=%h exp=%h", cyc, got_bus, exp_bus);
            end
        end
    endtask

    task automatic run_directed(input string name, input bit [15:0] vmask, input int exp_done_at,
                                input int chk_cyc, input int chk_row, input logic chk_v,
                                input logic [DW-1:0] chk_d);
        int base, done_at, letter;
        base = cyc; done_at = -1; letter = 0;
        for (int k = 0; k < exp_done_at + 3; k++) begin
            start = (k == 0); len = 8'd3;
            vld = vmask[k];
            if (vld) begin
                data = beat(letter);
                letter++;
            end else begin
                data = {$urandom(), $urandom()};
            end
            step();
            n_chk++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc - base, got_bus, exp_bus);
            end
            if (done === 1'b1) done_at = cyc - base;
            if (cyc - base == chk_cyc) begin
                n_chk++;
                if (xv[chk_row] !== chk_v || x[chk_row*DW +: DW] !== chk_d) begin
                    n_fail++;
                    $display("FAIL %s_row%0d got=%b/%h exp=%b/%h", name, chk_row,
                             xv[chk_row], x[chk_row*DW +: DW], chk_v, chk_d);
                end
            end
        end
        vld = 0;
        n_chk++;
        if (done_at !== exp_done_at) begin
            n_fail++;
            $display("FAIL %s_done_cycle got=%0d exp=%0d", name, done_at, exp_done_at);
        end
    endtask

    task automatic test_basic();
        run_directed("basic", 16'b0000_0000_0000_1110, 7, 5, 3, 1'b1, 16'h0A03);
        run_directed("basic_row0", 16'b0000_0000_0000_1110, 7, 3, 0, 1'b1, 16'h0B00);
    endtask

    task automatic test_bubble();
        run_directed("bubble", 16'b0000_0000_0001_1010, 8, 5, 2, 1'b0, 16'h0000);
    endtask

    task automatic test_zero_len_ignored_start();
        int base;
        base = cyc;
        for (int k = 0; k < 12; k++) begin
            start = (k == 0) || (k >= 2 && k <= 4);
            len   = (k == 0) ? 8'd0 : (k == 2) ? 8'd2 : 8'd5;
            vld   = (k >= 3 && k <= 7);
            data  = {$urandom(), $urandom()};
            step();
            n_chk++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL zero_ignored cyc=%0d got=%h exp=%h", cyc - base, got_bus, exp_bus);
            end
            if (k == 0) begin
                n_chk++;
                if (done !== 1'b1 || busy !== 1'b0 || xv !== '0) begin
                    n_fail++;
                    $display("FAIL zero_len_done got=%b%b%h exp=10_0", done, busy, xv);
                end
            end
            if (k == 4) begin
                n_chk++;
                if (rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignored_start_len got_rdy=%b exp=0", rdy);
                end
            end
        end
        start = 0; vld = 0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            start = (k == 0); len = 8'd5;
            vld   = (k >= 1);
            rst   = (k == 3);
            data  = {$urandom(), $urandom()};
            step();
            rst = 0;
            n_chk++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d got=%h exp=%h", k + 1, got_bus, exp_bus);
            end
            if (k == 3) begin
                n_chk++;
                if (xv !== '0 || rdy !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_idle got=%h%b%b exp=000", xv, rdy, busy);
                end
            end
            if (k > 3 && done === 1'b1) seen = 1;
            vld = 0;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done got=%b exp=0", seen);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(0, 5) == 0);
            len   = 8'($urandom_range(0, 9));
            vld   = ($urandom_range(0, 3) != 0);
            data  = {$urandom(), $urandom()};
            step();
            n_chk++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_bus, exp_bus);
            end
        end
        start = 0; vld = 0;
        for (int k = 0; k < 20; k++) step();
        // Longest tile the length field allows.
        for (int k = 0; k < 265; k++) begin
            start = (k == 0); len = 8'd255;
            vld   = (k != 0);
            data  = {$urandom(), $urandom()};
            step();
            n_chk++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL max_len cyc=%0d got=%h exp=%h", cyc, got_bus, exp_bus);
            end
        end
        start = 0; vld = 0;
    endtask

    task automatic test_rows1_back_to_back();
        logic [DW-1:0] bd [12];
        bit            bv [12];
        logic [3+1+DW-1:0] e;
        for (int k = 0; k < 12; k++) begin
            bv[k] = (k == 1 || k == 2 || k == 5 || k == 6);
            bd[k] = 16'($urandom());
        end
        for (int k = 0; k < 11; k++) begin
            start1 = (k == 0 || k == 4); len1 = 8'd2;
            vld1   = bv[k];
            data1  = bd[k];
            @(posedge clk);
            #1;
            e = {(k + 1 == 1 || k + 1 == 2 || k + 1 == 5 || k + 1 == 6),
                 (k + 1 >= 1 && k + 1 <= 3) || (k + 1 >= 5 && k + 1 <= 7),
                 (k + 1 == 3 || k + 1 == 7),
                 bv[k], bv[k] ? bd[k] : 16'h0000};
            n_chk++;
            if ({rdy1, busy1, done1, xv1, x1} !== e) begin
                n_fail++;
                $display("FAIL rows1_b2b cyc=%0d got=%h exp=%h", k + 1,
                         {rdy1, busy1, done1, xv1, x1}, e);
            end
        end
        start1 = 0; vld1 = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_zero_len_ignored_start();
        test_reset_mid();
        test_random();
        test_rows1_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
